// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types, default parameters and helpers for the pong court
// Contents:
//   state_e  : court FSM state encoding (driven out on the state port)
//   dir_e    : ball travel direction (RIGHT = toward bit 0, LEFT = toward bit N_LEDS-1)
//   player_e : player identity (LEFT = 1 matches the winner output encoding)
//   DEF_*    : default values for the pong_court parameters
//   sat_sub  : subtraction clamped to a floor, used for the rally speed-up
package pong_pkg;

  localparam int DEF_N_LEDS        = 16;
  localparam int DEF_HIT_WIN       = 2;
  localparam int DEF_STEP_INIT     = 12500000;
  localparam int DEF_STEP_DEC      = 1000000;
  localparam int DEF_STEP_MIN      = 2500000;
  localparam int DEF_WIN_SCORE     = 7;
  localparam int DEF_SERVE_TIMEOUT = 20;
  localparam int DEF_POINT_HOLD    = 25000000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_RALLY = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  typedef enum logic {
    PL_RIGHT = 1'b0,
    PL_LEFT  = 1'b1
  } player_e;

  function automatic int sat_sub(input int value, input int dec, input int floor_v);
    if (value - dec < floor_v) begin
      return floor_v;
    end
    return value - dec;
  endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// rtl/pong_tick_gen.sv - loadable down-counter producing the ball step tick
// Ports:
//   clk, reset : clock, asynchronous active-high reset (count clears to 0)
//   en_i       : count enable; tick_o is only raised while enabled
//   load_i     : restart the period from period_i (count = period_i - 1)
//   period_i   : step period in clk cycles (>= 1)
//   tick_o     : one-cycle pulse every period_i enabled cycles
module pong_tick_gen #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] period_i,
  output logic         tick_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign tick_o = en_i && (count_q == '0);

  // A load and a tick both restart the period, so the counter always
  // reloads on the cycle it fires.
  always_comb begin
    count_d = count_q;
    if (load_i || tick_o) begin
      count_d = period_i - W'(1);
    end else if (en_i) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pong_court.sv
// rtl/pong_court.sv - two-player LED pong court: serve, rally, scoring and match end
// Optional feature macro: PONG_SPEEDUP_EN (each successful return shortens the step period).
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   start        : one-cycle pulse, starts a match from IDLE or OVER
//   left_hit     : one-cycle pulse from the left player (bit N_LEDS-1 end)
//   right_hit    : one-cycle pulse from the right player (bit 0 end)
//   ball         : one-hot ball position; 0 in IDLE, all ones in POINT, winner's half in OVER
//   left_score   : left player's points
//   right_score  : right player's points
//   state        : current FSM state (pong_pkg::state_e)
//   match_over   : high while in OVER
//   winner       : 1 = left, 0 = right; only meaningful while match_over is high
module pong_court
  import pong_pkg::*;
#(
  parameter int N_LEDS        = DEF_N_LEDS,
  parameter int HIT_WIN       = DEF_HIT_WIN,
  parameter int STEP_INIT     = DEF_STEP_INIT,
  parameter int STEP_DEC      = DEF_STEP_DEC,
  parameter int STEP_MIN      = DEF_STEP_MIN,
  parameter int WIN_SCORE     = DEF_WIN_SCORE,
  parameter int SERVE_TIMEOUT = DEF_SERVE_TIMEOUT,
  parameter int POINT_HOLD    = DEF_POINT_HOLD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              left_hit,
  input  logic              right_hit,
  output logic [N_LEDS-1:0] ball,
  output logic [3:0]        left_score,
  output logic [3:0]        right_score,
  output logic [2:0]        state,
  output logic              match_over,
  output logic              winner
);

  localparam int CNT_W  = $clog2(STEP_INIT + 1);
  localparam int HOLD_W = (POINT_HOLD > 1) ? $clog2(POINT_HOLD) : 1;
  localparam int TO_W   = (SERVE_TIMEOUT > 1) ? $clog2(SERVE_TIMEOUT) : 1;

  localparam logic [N_LEDS-1:0] ONES   = '1;
  localparam logic [N_LEDS-1:0] END_R  = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] END_L  = ONES ^ (ONES >> 1);
  localparam logic [N_LEDS-1:0] WIN_R  = ONES >> (N_LEDS - HIT_WIN);
  localparam logic [N_LEDS-1:0] WIN_L  = ~(ONES >> HIT_WIN);
  localparam logic [N_LEDS-1:0] HALF_L = ~(ONES >> (N_LEDS / 2));
  localparam logic [N_LEDS-1:0] HALF_R = ~HALF_L;
  localparam logic [3:0]        SCORE_MAX = 4'(WIN_SCORE);

  if (N_LEDS < 4 || HIT_WIN < 1 || HIT_WIN > N_LEDS / 2 || WIN_SCORE < 1 ||
      WIN_SCORE > 15 || STEP_MIN < 1 || STEP_MIN > STEP_INIT || STEP_DEC < 0 ||
      SERVE_TIMEOUT < 1 || POINT_HOLD < 1) begin : g_bad_params
    $error("pong_court: parameter out of range");
  end

  state_e              state_q, state_d;
  logic [N_LEDS-1:0]   ball_q, ball_d;
  dir_e                dir_q, dir_d;
  player_e             server_q, server_d;
  logic [3:0]          lscore_q, lscore_d;
  logic [3:0]          rscore_q, rscore_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic [TO_W-1:0]     serve_cnt_q, serve_cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic    tick;
  logic    tick_en;
  logic    tick_load;
  logic    srv_hit;
  logic    rcv_hit;
  logic    in_win;
  logic    at_end;
  logic    award;
  logic    award_left;
  logic    enter_serve;
  player_e serve_side;
  logic    win_left;

  assign tick_en = (state_q == ST_SERVE) || (state_q == ST_RALLY);

  pong_tick_gen #(
    .W(CNT_W)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .en_i     (tick_en),
    .load_i   (tick_load),
    .period_i (period_d),
    .tick_o   (tick)
  );

  // The receiver is whoever the ball travels toward; the other player's
  // pulses are simply not looked at.
  assign srv_hit    = (server_q == PL_LEFT) ? left_hit : right_hit;
  assign rcv_hit    = (dir_q == DIR_RIGHT) ? right_hit : left_hit;
  assign in_win     = (dir_q == DIR_RIGHT) ? |(ball_q & WIN_R) : |(ball_q & WIN_L);
  assign at_end     = (dir_q == DIR_RIGHT) ? ball_q[0] : ball_q[N_LEDS-1];
  assign award_left = (dir_q == DIR_RIGHT);
  assign win_left   = (lscore_q == SCORE_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ball_q      <= '0;
      dir_q       <= DIR_RIGHT;
      server_q    <= PL_LEFT;
      lscore_q    <= '0;
      rscore_q    <= '0;
      period_q    <= CNT_W'(STEP_INIT);
      serve_cnt_q <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      ball_q      <= ball_d;
      dir_q       <= dir_d;
      server_q    <= server_d;
      lscore_q    <= lscore_d;
      rscore_q    <= rscore_d;
      period_q    <= period_d;
      serve_cnt_q <= serve_cnt_d;
      hold_q      <= hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ball_d      = ball_q;
    dir_d       = dir_q;
    server_d    = server_q;
    lscore_d    = lscore_q;
    rscore_d    = rscore_q;
    period_d    = period_q;
    serve_cnt_d = serve_cnt_q;
    hold_d      = hold_q;
    tick_load   = 1'b0;
    award       = 1'b0;
    enter_serve = 1'b0;
    serve_side  = server_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          lscore_d    = '0;
          rscore_d    = '0;
          server_d    = PL_LEFT;
          serve_side  = PL_LEFT;
          enter_serve = 1'b1;
        end
      end

      ST_SERVE: begin
        // The last timeout tick launches the ball just like a serve press.
        if (srv_hit || (tick && serve_cnt_q == TO_W'(SERVE_TIMEOUT - 1))) begin
          state_d   = ST_RALLY;
          period_d  = CNT_W'(STEP_INIT);
          tick_load = 1'b1;
        end else if (tick) begin
          serve_cnt_d = serve_cnt_q + TO_W'(1);
        end
      end

      ST_RALLY: begin
        // Hit is checked before tick so a simultaneous hit wins.
        if (rcv_hit) begin
          if (in_win) begin
            dir_d     = (dir_q == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
            tick_load = 1'b1;
`ifdef PONG_SPEEDUP_EN
            period_d  = CNT_W'(sat_sub(int'(period_q), STEP_DEC, STEP_MIN));
`endif
          end else begin
            award = 1'b1;
          end
        end else if (tick) begin
          if (at_end) begin
            award = 1'b1;
          end else begin
            ball_d = (dir_q == DIR_RIGHT) ? (ball_q >> 1) : (ball_q << 1);
          end
        end
      end

      ST_POINT: begin
        if (hold_q == HOLD_W'(POINT_HOLD - 1)) begin
          if (lscore_q == SCORE_MAX || rscore_q == SCORE_MAX) begin
            state_d = ST_OVER;
          end else begin
            server_d    = (server_q == PL_LEFT) ? PL_RIGHT : PL_LEFT;
            serve_side  = server_d;
            enter_serve = 1'b1;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (award) begin
      state_d = ST_POINT;
      hold_d  = '0;
      if (award_left) begin
        if (lscore_q < SCORE_MAX) begin
          lscore_d = lscore_q + 4'd1;
        end
      end else begin
        if (rscore_q < SCORE_MAX) begin
          rscore_d = rscore_q + 4'd1;
        end
      end
    end

    // Serving always restarts at the initial speed, heading away from the server.
    if (enter_serve) begin
      state_d     = ST_SERVE;
      ball_d      = (serve_side == PL_LEFT) ? END_L : END_R;
      dir_d       = (serve_side == PL_LEFT) ? DIR_RIGHT : DIR_LEFT;
      period_d    = CNT_W'(STEP_INIT);
      serve_cnt_d = '0;
      tick_load   = 1'b1;
    end
  end

  always_comb begin
    ball       = '0;
    match_over = 1'b0;
    winner     = 1'b0;
    case (state_q)
      ST_SERVE, ST_RALLY: ball = ball_q;
      ST_POINT:           ball = ONES;
      ST_OVER: begin
        match_over = 1'b1;
        winner     = win_left;
        ball       = win_left ? HALF_L : HALF_R;
      end
      default:            ball = '0;
    endcase
  end

  assign left_score  = lscore_q;
  assign right_score = rscore_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pong_court.sv
// tb/tb_pong_court.sv - directed vector and sequence bench for pong_court
module tb_pong_court;
  import pong_pkg::*;

  localparam int N = 8;

`ifdef PONG_SPEEDUP_EN
  localparam int EXP1 = 3;
  localparam int EXP2 = 2;
  localparam int EXP3 = 2;
`else
  localparam int EXP1 = 4;
  localparam int EXP2 = 4;
  localparam int EXP3 = 4;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         left_hit = 1'b0;
  logic         right_hit = 1'b0;
  logic [N-1:0] ball;
  logic [3:0]   left_score;
  logic [3:0]   right_score;
  logic [2:0]   state;
  logic         match_over;
  logic         winner;

  int n_tests = 0;
  int n_fail  = 0;

  pong_court #(
    .N_LEDS(8), .HIT_WIN(2), .STEP_INIT(4), .STEP_DEC(1), .STEP_MIN(2),
    .WIN_SCORE(3), .SERVE_TIMEOUT(3), .POINT_HOLD(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .left_hit    (left_hit),
    .right_hit   (right_hit),
    .ball        (ball),
    .left_score  (left_score),
    .right_score (right_score),
    .state       (state),
    .match_over  (match_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic       s;
    logic       l;
    logic       r;
    int         cyc;
    logic [7:0] b;
    logic [2:0] st;
    logic [3:0] ls;
    logic [3:0] rs;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] snap();
    return {11'd0, ball, state, left_score, right_score, match_over, winner};
  endfunction

  function automatic logic [31:0] pack(input logic [7:0] b, input logic [2:0] st,
                                       input logic [3:0] ls, input logic [3:0] rs,
                                       input logic ov, input logic wn);
    return {11'd0, b, st, ls, rs, ov, wn};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic l, input logic r, input int cyc,
                     input logic [7:0] b, input logic [2:0] st,
                     input logic [3:0] ls, input logic [3:0] rs);
    vec_t v;
    v.s = s; v.l = l; v.r = r; v.cyc = cyc;
    v.b = b; v.st = st; v.ls = ls; v.rs = rs;
    vecs.push_back(v);
  endtask

  task automatic step(input logic s, input logic l, input logic r);
    @(negedge clk);
    start = s; left_hit = l; right_hit = r;
    @(posedge clk);
    #1;
    start = 1'b0; left_hit = 1'b0; right_hit = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0; left_hit = 1'b0; right_hit = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ball(input logic [7:0] v, input int budget, input string name);
    int n = 0;
    while (ball !== v && n < budget) begin
      step(0, 0, 0);
      n++;
    end
    check(name, 32'(ball), 32'(v));
  endtask

  task automatic wait_state(input logic [2:0] v, input int budget, input string name);
    int n = 0;
    while (state !== v && n < budget) begin
      step(0, 0, 0);
      n++;
    end
    check(name, 32'(state), 32'(v));
  endtask

  task automatic measure(input logic [7:0] from, input logic [7:0] to,
                         input int exp_n, input string name);
    int n = 0;
    do begin
      step(0, 0, 0);
      n++;
    end while (ball === from && n < 20);
    check({name, "_cycles"}, 32'(n), 32'(exp_n));
    check({name, "_ball"}, 32'(ball), 32'(to));
  endtask

  // Left scores one point from SERVE, whichever side is serving.
  task automatic left_point(input logic srv_left, input logic [2:0] end_st, input string name);
    if (srv_left) begin
      step(0, 1, 0);
    end else begin
      step(0, 0, 1);
      wait_ball(8'h80, 60, {name, "_reach80"});
      step(0, 1, 0);
    end
    wait_ball(8'h10, 40, {name, "_reach10"});
    step(0, 0, 1);
    wait_state(end_st, 20, {name, "_end"});
  endtask

  initial begin
    int n;

    // Scenario 1 with ignored-input checks, end-bit miss, POINT hold and serve swap.
    add(0, 0, 0, 1, 8'h00, ST_IDLE,  0, 0);
    add(1, 0, 0, 1, 8'h80, ST_SERVE, 0, 0);
    add(0, 1, 0, 1, 8'h80, ST_RALLY, 0, 0);
    add(0, 0, 0, 3, 8'h80, ST_RALLY, 0, 0);
    add(0, 0, 0, 1, 8'h40, ST_RALLY, 0, 0);
    add(0, 1, 0, 1, 8'h40, ST_RALLY, 0, 0);
    add(1, 0, 0, 1, 8'h40, ST_RALLY, 0, 0);
    add(0, 0, 0, 2, 8'h20, ST_RALLY, 0, 0);
    add(0, 0, 0, 4, 8'h10, ST_RALLY, 0, 0);
    add(0, 0, 0, 4, 8'h08, ST_RALLY, 0, 0);
    add(0, 0, 0, 4, 8'h04, ST_RALLY, 0, 0);
    add(0, 0, 0, 4, 8'h02, ST_RALLY, 0, 0);
    add(0, 0, 0, 4, 8'h01, ST_RALLY, 0, 0);
    add(0, 0, 0, 3, 8'h01, ST_RALLY, 0, 0);
    add(0, 0, 0, 1, 8'hFF, ST_POINT, 1, 0);
    add(0, 0, 0, 3, 8'hFF, ST_POINT, 1, 0);
    add(0, 0, 0, 1, 8'h01, ST_SERVE, 1, 0);
    add(0, 1, 0, 1, 8'h01, ST_SERVE, 1, 0);
    add(0, 0, 1, 1, 8'h01, ST_RALLY, 1, 0);
    add(0, 0, 0, 4, 8'h02, ST_RALLY, 1, 0);
    add(0, 0, 1, 1, 8'h02, ST_RALLY, 1, 0);
    add(0, 0, 0, 3, 8'h04, ST_RALLY, 1, 0);

    do_reset();
    check("reset_state", snap(), 32'd0);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].s, vecs[i].l, vecs[i].r);
      for (int c = 1; c < vecs[i].cyc; c++) step(0, 0, 0);
      check($sformatf("vec%0d", i), snap(),
            pack(vecs[i].b, vecs[i].st, vecs[i].ls, vecs[i].rs, 1'b0, 1'b0));
    end

    // Scenario 2: return on the same cycle as a tick, then successive returns.
    do_reset();
    step(1, 0, 0);
    step(0, 1, 0);
    wait_ball(8'h02, 40, "s2_reach02");
    repeat (3) step(0, 0, 0);
    check("s2_pre_hit", 32'(ball), 32'h02);
    step(0, 0, 1);
    check("s2_hit_beats_tick", snap(), pack(8'h02, ST_RALLY, 0, 0, 0, 0));
    measure(8'h02, 8'h04, EXP1, "s2_step1");
    wait_ball(8'h40, 40, "s2_reach40");
    step(0, 1, 0);
    measure(8'h40, 8'h20, EXP2, "s2_step2");
    wait_ball(8'h01, 40, "s2_reach01");
    step(0, 0, 1);
    measure(8'h01, 8'h02, EXP3, "s2_step3");

    // Scenario 3: out-of-window return awards the opponent; start ignored in POINT.
    do_reset();
    step(1, 0, 0);
    step(0, 1, 0);
    wait_ball(8'h10, 40, "s3_reach10");
    step(0, 0, 1);
    check("s3_point", snap(), pack(8'hFF, ST_POINT, 1, 0, 0, 0));
    step(1, 0, 0);
    check("s3_start_ignored", snap(), pack(8'hFF, ST_POINT, 1, 0, 0, 0));
    n = 2;
    while (n < 20) begin
      step(0, 0, 0);
      if (ball !== 8'hFF) break;
      n++;
    end
    check("s3_hold_cycles", 32'(n), 32'd4);
    check("s3_serve_right", snap(), pack(8'h01, ST_SERVE, 1, 0, 0, 0));

    // Scenario 4: automatic serve.
    do_reset();
    step(1, 0, 0);
    n = 0;
    do begin
      step(0, 0, 0);
      n++;
    end while (state !== ST_RALLY && n < 40);
    check("s4_autoserve_cycles", 32'(n), 32'd12);
    check("s4_autoserve_ball", 32'(ball), 32'h80);
    measure(8'h80, 8'h40, 4, "s4_first_step");

    // Scenario 5: left takes the match.
    wait_ball(8'h10, 40, "s5_p1_reach10");
    step(0, 0, 1);
    wait_state(ST_SERVE, 20, "s5_p1_end");
    left_point(1'b0, ST_SERVE, "s5_p2");
    check("s5_after_p2", snap(), pack(8'h80, ST_SERVE, 2, 0, 0, 0));
    left_point(1'b1, ST_OVER, "s5_p3");
    check("s5_over", snap(), pack(8'hF0, ST_OVER, 3, 0, 1, 1));
    step(1, 0, 0);
    check("s5_restart", snap(), pack(8'h80, ST_SERVE, 0, 0, 0, 0));

    // Scenario 6: asynchronous reset mid-rally at left_score = 2.
    left_point(1'b1, ST_SERVE, "s6_p1");
    left_point(1'b0, ST_SERVE, "s6_p2");
    step(0, 1, 0);
    wait_ball(8'h20, 40, "s6_reach20");
    check("s6_pre_reset", snap(), pack(8'h20, ST_RALLY, 2, 0, 0, 0));
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("s6_async_reset", snap(), 32'd0);
    @(posedge clk);
    #1;
    check("s6_reset_held", snap(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0);
    check("s6_idle_after", snap(), 32'd0);
    step(1, 0, 0);
    check("s6_new_match", snap(), pack(8'h80, ST_SERVE, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
